// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL constants, field widths and the D-channel response record.
// Imported by the RAM responder and its pipe slot.
package tl_ul_pkg;

   localparam int unsigned TL_AW = 32;
   localparam int unsigned TL_DW = 32;
   localparam int unsigned TL_MW = TL_DW / 8;
   localparam int unsigned TL_SZW = 3;
   localparam int unsigned TL_SRCW = 4;
   localparam int unsigned TL_OPW = 3;

   typedef enum logic [TL_OPW-1:0] {
      A_PUT_FULL    = 3'd0,
      A_PUT_PARTIAL = 3'd1,
      A_ARITH       = 3'd2,
      A_LOGIC       = 3'd3,
      A_GET         = 3'd4,
      A_INTENT      = 3'd5
   } a_op_e;

   typedef enum logic [TL_OPW-1:0] {
      D_ACCESS_ACK      = 3'd0,
      D_ACCESS_ACK_DATA = 3'd1,
      D_HINT_ACK        = 3'd2
   } d_op_e;

   typedef struct packed {
      logic [TL_OPW-1:0]  opcode;
      logic [1:0]         param;
      logic [TL_SZW-1:0]  size;
      logic [TL_SRCW-1:0] source;
      logic               sink;
      logic               denied;
      logic [TL_DW-1:0]   data;
      logic               corrupt;
   } d_rsp_t;

endpackage

// File: rtl/tl_ul_pipe_slot.sv
// Single-entry D-channel holding register. Handshake: a beat transfers on a
// clock edge where valid && ready; the slot accepts a new beat whenever it is
// empty or its current beat leaves on the same edge.
module tl_ul_pipe_slot
   import tl_ul_pkg::*;
(
   input  logic   clk_i,
   input  logic   rst_ni,
   input  logic   load_i,
   input  d_rsp_t rsp_i,
   input  logic   d_ready_i,
   output logic   d_valid_o,
   output d_rsp_t rsp_o,
   output logic   a_ready_o
);

   logic   valid_q;
   d_rsp_t rsp_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         rsp_q   <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         rsp_q   <= rsp_i;
      end else if (d_ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign d_valid_o = valid_q;
   assign rsp_o     = rsp_q;
   assign a_ready_o = !valid_q || d_ready_i;

endmodule

// File: rtl/tl_ul_ram_responder.sv
// TileLink-UL slave backed by a flop-based word memory. Requests are decoded
// and the memory accessed on A fire; the response sits in a one-entry slot.
module tl_ul_ram_responder
   import tl_ul_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned DEPTH     = 16
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               a_valid,
   output logic               a_ready,
   input  logic [TL_OPW-1:0]  a_opcode,
   input  logic [2:0]         a_param,
   input  logic [TL_SZW-1:0]  a_size,
   input  logic [TL_SRCW-1:0] a_source,
   input  logic [TL_AW-1:0]   a_address,
   input  logic [TL_MW-1:0]   a_mask,
   input  logic [TL_DW-1:0]   a_data,
   input  logic               a_corrupt,
   output logic               d_valid,
   input  logic               d_ready,
   output logic [TL_OPW-1:0]  d_opcode,
   output logic [1:0]         d_param,
   output logic [TL_SZW-1:0]  d_size,
   output logic [TL_SRCW-1:0] d_source,
   output logic               d_sink,
   output logic               d_denied,
   output logic [TL_DW-1:0]   d_data,
   output logic               d_corrupt
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] SPAN  = 32'(4 * DEPTH);

   logic [TL_DW-1:0] mem_q [DEPTH];

   logic [31:0]      offset;
   logic [IDX_W-1:0] idx;
   logic             in_range;
   logic             misaligned;
   logic             op_ok;
   logic             is_put;
   logic             denied;
   logic             a_fire;
   logic             wr_en;
   d_rsp_t           rsp_d;
   d_rsp_t           rsp_q;
   logic             unused_bits;

   // Unsigned 32-bit subtraction: addresses below BASE_ADDR wrap to huge offsets.
   assign offset   = a_address - BASE_ADDR;
   assign idx      = offset[IDX_W+1:2];
   assign in_range = offset < SPAN;

   always_comb begin
      misaligned = 1'b0;
      case (a_size)
         3'd1:    misaligned = a_address[0];
         3'd2:    misaligned = |a_address[1:0];
         default: misaligned = 1'b0;
      endcase
   end

   assign is_put = (a_opcode == A_PUT_FULL) || (a_opcode == A_PUT_PARTIAL);
   assign op_ok  = is_put || (a_opcode == A_GET);
   assign denied = !in_range || (a_size > 3'd2) || misaligned || !op_ok;
   assign a_fire = a_valid && a_ready;
   assign wr_en  = a_fire && is_put && !denied && !a_corrupt;

   always_comb begin
      rsp_d        = '0;
      rsp_d.size   = a_size;
      rsp_d.source = a_source;
      rsp_d.denied = denied;
      if (denied) begin
         case (a_opcode)
            A_ARITH, A_LOGIC, A_GET: begin
               rsp_d.opcode  = D_ACCESS_ACK_DATA;
               rsp_d.corrupt = 1'b1;
            end
            A_INTENT: rsp_d.opcode = D_HINT_ACK;
            default:  rsp_d.opcode = D_ACCESS_ACK;
         endcase
      end else if (a_opcode == A_GET) begin
         rsp_d.opcode = D_ACCESS_ACK_DATA;
         rsp_d.data   = mem_q[idx];
      end else begin
         rsp_d.opcode = D_ACCESS_ACK;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en) begin
         for (int b = 0; b < int'(TL_MW); b++) begin
            if (a_mask[b]) begin
               mem_q[idx][8*b +: 8] <= a_data[8*b +: 8];
            end
         end
      end
   end

   tl_ul_pipe_slot u_slot (
      .clk_i     (clock),
      .rst_ni    (reset_n),
      .load_i    (a_fire),
      .rsp_i     (rsp_d),
      .d_ready_i (d_ready),
      .d_valid_o (d_valid),
      .rsp_o     (rsp_q),
      .a_ready_o (a_ready)
   );

   assign d_opcode  = rsp_q.opcode;
   assign d_param   = rsp_q.param;
   assign d_size    = rsp_q.size;
   assign d_source  = rsp_q.source;
   assign d_sink    = rsp_q.sink;
   assign d_denied  = rsp_q.denied;
   assign d_data    = rsp_q.data;
   assign d_corrupt = rsp_q.corrupt;

   assign unused_bits = ^{a_param, offset[31:IDX_W+2], offset[1:0]};

endmodule

// File: tb/tb_tl_ul_ram_responder.sv
// Directed bench for tl_ul_ram_responder with hand-computed responses.
module tb_tl_ul_ram_responder;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int unsigned DEPTH = 16;

  logic        clk;
  logic        reset_n;
  logic        a_valid, a_ready;
  logic [2:0]  a_opcode, a_param, a_size;
  logic [3:0]  a_source, a_mask;
  logic [31:0] a_address, a_data;
  logic        a_corrupt;
  logic        d_valid, d_ready;
  logic [2:0]  d_opcode, d_size;
  logic [1:0]  d_param;
  logic [3:0]  d_source;
  logic        d_sink, d_denied, d_corrupt;
  logic [31:0] d_data;

  int checks = 0;
  int errors = 0;

  // {accepted, early_valid, valid, opcode, param, size, source, sink, denied, data, corrupt}
  logic [49:0] rsp;
  logic [49:0] exp;

  tl_ul_ram_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clock(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data), .a_corrupt(a_corrupt),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_denied(d_denied),
    .d_data(d_data), .d_corrupt(d_corrupt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [49:0] mk_exp(input logic [2:0] op, input logic [2:0] sz,
                                         input logic [3:0] src, input logic den,
                                         input logic [31:0] data, input logic corr);
    return {3'b101, op, 2'b00, sz, src, 1'b0, den, data, corr};
  endfunction

  task automatic set_a(input logic [2:0] op, input logic [2:0] sz, input logic [3:0] src,
                       input logic [31:0] addr, input logic [3:0] mask,
                       input logic [31:0] data, input logic corr);
    a_opcode = op; a_size = sz; a_source = src; a_address = addr;
    a_mask = mask; a_data = data; a_corrupt = corr; a_param = 3'd0;
  endtask

  // driver: one request from idle, response captured the cycle after acceptance
  task automatic issue(input logic [2:0] op, input logic [2:0] sz, input logic [3:0] src,
                       input logic [31:0] addr, input logic [3:0] mask,
                       input logic [31:0] data, input logic corr);
    logic acc, early;
    set_a(op, sz, src, addr, mask, data, corr);
    a_valid = 1'b1;
    d_ready = 1'b1;
    @(negedge clk);
    acc = a_ready;
    early = d_valid;
    @(posedge clk);
    #1 a_valid = 1'b0;
    @(negedge clk);
    rsp = {acc, early, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied,
           (d_opcode == 3'd1) ? d_data : 32'h0, d_corrupt};
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; a_valid = 1'b0; d_ready = 1'b1;
    set_a(3'd0, 3'd0, 4'd0, 32'h0, 4'h0, 32'h0, 1'b0);
    #2;
    checks++;
    if ({a_ready, d_valid} !== 2'b10) begin
      errors++; $display("FAIL reset_hs got a_ready=%b d_valid=%b exp 1 0", a_ready, d_valid);
    end
    checks++;
    if ({d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt} !== '0) begin
      errors++; $display("FAIL reset_dfields got data=%h opcode=%0d exp all zero", d_data, d_opcode);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (a_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_ready got %b exp 1", a_ready);
    end
  endtask

  task automatic test_put_get;
    issue(3'd0, 3'd2, 4'd3, BASE + 8, 4'hF, 32'hDEADBEEF, 1'b0);
    exp = mk_exp(3'd0, 3'd2, 4'd3, 1'b0, 32'h0, 1'b0);
    checks++;
    if (rsp !== exp) begin errors++; $display("FAIL s1_put got %h exp %h", rsp, exp); end
    issue(3'd4, 3'd2, 4'd3, BASE + 8, 4'h0, 32'h0, 1'b0);
    exp = mk_exp(3'd1, 3'd2, 4'd3, 1'b0, 32'hDEADBEEF, 1'b0);
    checks++;
    if (rsp !== exp) begin errors++; $display("FAIL s1_get got %h exp %h", rsp, exp); end
  endtask

  task automatic test_partial;
    issue(3'd1, 3'd2, 4'd5, BASE + 8, 4'b0101, 32'h11223344, 1'b0);
    exp = mk_exp(3'd0, 3'd2, 4'd5, 1'b0, 32'h0, 1'b0);
    checks++;
    if (rsp !== exp) begin errors++; $display("FAIL s2_put got %h exp %h", rsp, exp); end
    issue(3'd4, 3'd2, 4'd6, BASE + 8, 4'hF, 32'h0, 1'b0);
    exp = mk_exp(3'd1, 3'd2, 4'd6, 1'b0, 32'hDE22BE44, 1'b0);
    checks++;
    if (rsp !== exp) begin errors++; $display("FAIL s2_get got %h exp %h", rsp, exp); end
    issue(3'd4, 3'd1, 4'd7, BASE + 10, 4'hC, 32'h0, 1'b0);
    exp = mk_exp(3'd1, 3'd1, 4'd7, 1'b0, 32'hDE22BE44, 1'b0);
    checks++;
    if (rsp !== exp) begin errors++; $display("FAIL s2_get_half got %h exp %h", rsp, exp); end
  endtask

  task automatic test_denied;
    issue(3'd4, 3'd2, 4'd1, BASE + 4 * DEPTH, 4'hF, 32'h0, 1'b0);
    exp = mk_exp(3'd1, 3'd2, 4'd1, 1'b1, 32'h0, 1'b1);
    checks++;
    if (rsp !== exp) begin errors++; $display("FAIL s3_get_oor got %h exp %h", rsp, exp); end
    issue(3'd4, 3'd2, 4'd2, BASE + 2, 4'hF, 32'h0, 1'b0);
    exp = mk_exp(3'd1, 3'd2, 4'd2, 1'b1, 32'h0, 1'b1);
    checks++;
    if (rsp !== exp) begin errors++; $display("FAIL s3_get_unaligned got %h exp %h", rsp, exp); end
    issue(3'd2, 3'd2, 4'd3, BASE, 4'hF, 32'hFFFFFFFF, 1'b0);
    exp = mk_exp(3'd1, 3'd2, 4'd3, 1'b1, 32'h0, 1'b1);
    checks++;
    if (rsp !== exp) begin errors++; $display("FAIL s3_arith got %h exp %h", rsp, exp); end
    issue(3'd5, 3'd2, 4'd4, BASE + 8, 4'hF, 32'h0, 1'b0);
    exp = mk_exp(3'd2, 3'd2, 4'd4, 1'b1, 32'h0, 1'b0);
    checks++;
    if (rsp !== exp) begin errors++; $display("FAIL s3_intent got %h exp %h", rsp, exp); end
    issue(3'd0, 3'd3, 4'd8, BASE + 8, 4'hF, 32'h0BAD0BAD, 1'b0);
    exp = mk_exp(3'd0, 3'd3, 4'd8, 1'b1, 32'h0, 1'b0);
    checks++;
    if (rsp !== exp) begin errors++; $display("FAIL s3_put_size3 got %h exp %h", rsp, exp); end
    issue(3'd0, 3'd2, 4'd9, BASE - 4, 4'hF, 32'h0BAD0BAD, 1'b0);
    exp = mk_exp(3'd0, 3'd2, 4'd9, 1'b1, 32'h0, 1'b0);
    checks++;
    if (rsp !== exp) begin errors++; $display("FAIL s3_put_below got %h exp %h", rsp, exp); end
    issue(3'd6, 3'd2, 4'd10, BASE + 8, 4'hF, 32'h0, 1'b0);
    exp = mk_exp(3'd0, 3'd2, 4'd10, 1'b1, 32'h0, 1'b0);
    checks++;
    if (rsp !== exp) begin errors++; $display("FAIL s3_op6 got %h exp %h", rsp, exp); end
    issue(3'd4, 3'd2, 4'd11, BASE, 4'hF, 32'h0, 1'b0);
    exp = mk_exp(3'd1, 3'd2, 4'd11, 1'b0, 32'h0, 1'b0);
    checks++;
    if (rsp !== exp) begin errors++; $display("FAIL s3_mem_base got %h exp %h", rsp, exp); end
    issue(3'd4, 3'd2, 4'd12, BASE + 8, 4'hF, 32'h0, 1'b0);
    exp = mk_exp(3'd1, 3'd2, 4'd12, 1'b0, 32'hDE22BE44, 1'b0);
    checks++;
    if (rsp !== exp) begin errors++; $display("FAIL s3_mem_word2 got %h exp %h", rsp, exp); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] vals [3];
    vals[0] = 32'hA5A50004; vals[1] = 32'h5A5A0005; vals[2] = 32'h0F0F0006;
    for (int i = 0; i < 3; i++) begin
      issue(3'd0, 3'd2, 4'd0, BASE + 32'(16 + 4 * i), 4'hF, vals[i], 1'b0);
    end
    // stall: first Get accepted, second held off for five cycles
    set_a(3'd4, 3'd2, 4'd1, BASE + 16, 4'hF, 32'h0, 1'b0);
    a_valid = 1'b1; d_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1) begin errors++; $display("FAIL s4_first_ready got %b exp 1", a_ready); end
    @(posedge clk);
    #1 set_a(3'd4, 3'd2, 4'd2, BASE + 20, 4'hF, 32'h0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({d_valid, a_ready, d_opcode, d_source, d_data} !== {2'b10, 3'd1, 4'd1, vals[0]}) begin
        errors++;
        $display("FAIL s4_stall cyc %0d got v=%b rdy=%b op=%0d src=%0d data=%h exp v=1 rdy=0 op=1 src=1 data=%h",
                 c, d_valid, a_ready, d_opcode, d_source, d_data, vals[0]);
      end
      @(posedge clk);
      #1;
    end
    d_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({d_valid, a_ready, d_data} !== {2'b11, vals[0]}) begin
      errors++; $display("FAIL s4_release got v=%b rdy=%b data=%h exp 1 1 %h", d_valid, a_ready, d_data, vals[0]);
    end
    @(posedge clk);
    #1 set_a(3'd4, 3'd2, 4'd3, BASE + 24, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    checks++;
    if ({d_valid, d_source, d_data} !== {1'b1, 4'd2, vals[1]}) begin
      errors++; $display("FAIL s4_b2b_1 got v=%b src=%0d data=%h exp 1 2 %h", d_valid, d_source, d_data, vals[1]);
    end
    @(posedge clk);
    #1 a_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({d_valid, d_source, d_data} !== {1'b1, 4'd3, vals[2]}) begin
      errors++; $display("FAIL s4_b2b_2 got v=%b src=%0d data=%h exp 1 3 %h", d_valid, d_source, d_data, vals[2]);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (d_valid !== 1'b0) begin errors++; $display("FAIL s4_drain got d_valid=%b exp 0", d_valid); end
    // write at N then read at N+1 with no idle cycle
    @(posedge clk);
    #1 set_a(3'd0, 3'd2, 4'd4, BASE + 28, 4'hF, 32'h77777777, 1'b0);
    a_valid = 1'b1;
    @(posedge clk);
    #1 set_a(3'd4, 3'd2, 4'd5, BASE + 28, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    checks++;
    if ({d_valid, d_opcode, d_source} !== {1'b1, 3'd0, 4'd4}) begin
      errors++; $display("FAIL s4_wr_ack got v=%b op=%0d src=%0d exp 1 0 4", d_valid, d_opcode, d_source);
    end
    @(posedge clk);
    #1 a_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({d_valid, d_opcode, d_source, d_data} !== {1'b1, 3'd1, 4'd5, 32'h77777777}) begin
      errors++; $display("FAIL s4_raw got v=%b op=%0d src=%0d data=%h exp 1 1 5 77777777",
                         d_valid, d_opcode, d_source, d_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midflight;
    logic stale;
    issue(3'd0, 3'd2, 4'd1, BASE + 12, 4'hF, 32'hCAFEF00D, 1'b0);
    set_a(3'd4, 3'd2, 4'd2, BASE + 12, 4'hF, 32'h0, 1'b0);
    a_valid = 1'b1; d_ready = 1'b0;
    @(posedge clk);
    #1 a_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({d_valid, d_data} !== {1'b1, 32'hCAFEF00D}) begin
      errors++; $display("FAIL s5_pending got v=%b data=%h exp 1 cafef00d", d_valid, d_data);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({d_valid, a_ready, d_data} !== {2'b01, 32'h0}) begin
      errors++; $display("FAIL s5_async got v=%b rdy=%b data=%h exp 0 1 0", d_valid, a_ready, d_data);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    d_ready = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1 stale = stale | d_valid;
    end
    checks++;
    if (stale !== 1'b0) begin errors++; $display("FAIL s5_stale got %b exp 0", stale); end
    issue(3'd4, 3'd2, 4'd3, BASE + 12, 4'hF, 32'h0, 1'b0);
    exp = mk_exp(3'd1, 3'd2, 4'd3, 1'b0, 32'h0, 1'b0);
    checks++;
    if (rsp !== exp) begin errors++; $display("FAIL s5_mem_cleared got %h exp %h", rsp, exp); end
  endtask

  task automatic test_corrupt_put;
    issue(3'd0, 3'd2, 4'd6, BASE, 4'hF, 32'h12345678, 1'b1);
    exp = mk_exp(3'd0, 3'd2, 4'd6, 1'b0, 32'h0, 1'b0);
    checks++;
    if (rsp !== exp) begin errors++; $display("FAIL s6_put got %h exp %h", rsp, exp); end
    issue(3'd4, 3'd2, 4'd7, BASE, 4'hF, 32'h0, 1'b0);
    exp = mk_exp(3'd1, 3'd2, 4'd7, 1'b0, 32'h0, 1'b0);
    checks++;
    if (rsp !== exp) begin errors++; $display("FAIL s6_get got %h exp %h", rsp, exp); end
  endtask

  initial begin
    test_reset();
    test_put_get();
    test_partial();
    test_denied();
    test_back_to_back();
    test_reset_midflight();
    test_corrupt_put();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tl_ul_ram_responder.md
TL_UL_RAM_RESPONDER -- requirements
Module: tl_ul_ram_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0.
REQ-002 SHALL have parameter DEPTH, default 16: number of 32-bit words, power of two, 2..256.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clock input 1, rising-edge clock.
REQ-004 SHALL have reset_n, input, width 1: asynchronous active-low reset.
REQ-005 SHALL have A-channel handshake ports:
- a_valid input 1
- a_ready output 1
REQ-006 SHALL have A-channel fields:
- a_opcode input 3
- a_param input 3
- a_size input 3
- a_source input 4
- a_address input 32
- a_mask input 4
- a_data input 32
- a_corrupt input 1
REQ-007 SHALL have D-channel handshake ports:
- d_valid output 1
- d_ready input 1
REQ-008 SHALL have D-channel fields:
- d_opcode output 3
- d_param output 2
- d_size output 3
- d_source output 4
- d_sink output 1
- d_denied output 1
- d_data output 32
- d_corrupt output 1

Function
REQ-009 SHALL accept an A beat only on a_valid&&a_ready; a_ready = !d_valid || d_ready (single-entry pipe slot).
REQ-010 SHALL present the response on the cycle after A fire: fixed latency 1, never earlier.
REQ-011 SHALL hold all D fields stable while d_valid&&!d_ready.
REQ-012 SHALL, on D fire with a simultaneous A fire, load the new response with no bubble, giving full throughput.
REQ-013 SHALL, on D fire without A fire, clear d_valid next cycle.
REQ-014 SHALL respond to Get (4) with opcode AccessAckData (1) and d_data = mem[idx], where idx = (a_address-BASE_ADDR)>>2; all 4 bytes SHALL be returned regardless of mask.
REQ-015 SHALL respond to PutFullData (0) and PutPartialData (1) with opcode AccessAck (0), writing byte lane i of mem[idx] iff a_mask[i]=1.
REQ-016 SHALL make a write accepted at cycle N visible to a Get accepted at cycle N+1.
REQ-017 SHALL copy d_size from a_size and d_source from a_source; d_param=0 and d_sink=0 always.
REQ-018 SHALL deny a request with no memory write, setting d_denied=1, when any of the following holds:
- address outside [BASE_ADDR, BASE_ADDR+4*DEPTH)
- a_size>2
- address not aligned to 2^a_size
- opcode not in {0,1,4}
REQ-019 SHALL select the opcode of a denied response as follows: opcodes 2,3,4 -> AccessAckData, 0,1 -> AccessAck, 5 (Intent) -> HintAck (2), others -> AccessAck.
REQ-020 SHALL, when a denied response is AccessAckData, drive d_data=0 and d_corrupt=1; d_corrupt SHALL be 0 otherwise.
REQ-021 SHALL drop a Put with a_corrupt=1: no write, response AccessAck with d_denied=0.
REQ-022 SHALL use the address offset modulo 2^32 with no wrap into range; offsets below BASE_ADDR are out of range.

Reset
REQ-023 SHALL, asynchronously on reset_n=0, force d_valid=0 and all D fields and every memory word to 0.
REQ-024 SHALL drive a_ready=1 during and immediately after reset.
REQ-025 SHALL discard a pending response when reset asserts mid-handshake; no D beat is emitted after release for pre-reset requests.
REQ-026 SHALL release reset synchronously to clock; upstream provides synchronized deassertion.

Structure
REQ-027 SHALL take opcode constants (A: PutFull=0, PutPartial=1, Arith=2, Logic=3, Get=4, Intent=5; D: AccessAck=0, AccessAckData=1, HintAck=2) and field widths from shared package tl_ul_pkg.
REQ-028 SHALL implement the D holding register plus the a_ready logic as sub-module tl_ul_pipe_slot; the decode and memory SHALL remain in the top level.
REQ-029 SHALL implement the memory as flops (DEPTH<=256), not an SRAM macro.

Verification
REQ-030 SHALL be covered by scenario 1: PutFull addr=BASE+8, mask=F, data=DEADBEEF, source=3, then Get BASE+8 -> AccessAck src 3, then AccessAckData data=DEADBEEF, d_denied=0.
REQ-031 SHALL be covered by scenario 2: PutPartial BASE+8, mask=0101, data=11223344, over DEADBEEF -> a following Get returns DE22BE44.
REQ-032 SHALL be covered by scenario 3: Get BASE+4*DEPTH, Get BASE+2 size=2, and Arith BASE -> each gets AccessAckData, d_denied=1, d_corrupt=1, d_data=0, memory unchanged.
REQ-033 SHALL be covered by scenario 4: d_ready held 0 for 5 cycles with a_valid=1 -> a_ready=0 and D fields stable throughout; after d_ready=1, back-to-back responses, one per cycle, in order.
REQ-034 SHALL be covered by scenario 5: reset_n pulsed low while d_valid=1,d_ready=0 -> d_valid drops immediately, no stale beat after release, and a Get of a previously written word returns 0.
REQ-035 SHALL be covered by scenario 6: Put with a_corrupt=1 to BASE -> AccessAck, d_denied=0, a following Get returns 0.
